// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control slice: opcodes, functs,
// ALU select codes, mux selects and the control FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_I_EX    = 4'd10
  } state_t;

  localparam state_t S_I_WB = state_t'(4'd11);

  // Moore control word; pc_en is formed outside it from the live zero flag.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_select;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU select decode: funct for R-type execute, opcode for
// immediate execute, plus the R-type supported flag and immediate extension.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] r_select,
  output logic       r_supported,
  output logic [2:0] i_select,
  output logic       i_zero_ext
);

  always_comb begin
    r_select    = ALU_ADD;
    r_supported = 1'b1;
    case (funct)
      FN_ADD:  r_select = ALU_ADD;
      FN_SUB:  r_select = ALU_SUB;
      FN_AND:  r_select = ALU_AND;
      FN_OR:   r_select = ALU_OR;
      FN_XOR:  r_select = ALU_XOR;
      default: r_supported = 1'b0;
    endcase
  end

  // Logical immediates are zero-extended; addi keeps sign extension.
  always_comb begin
    i_select   = ALU_ADD;
    i_zero_ext = 1'b0;
    case (opcode)
      OP_ANDI: begin i_select = ALU_AND; i_zero_ext = 1'b1; end
      OP_ORI:  begin i_select = ALU_OR;  i_zero_ext = 1'b1; end
      OP_XORI: begin i_select = ALU_XOR; i_zero_ext = 1'b1; end
      default: i_select = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// Moore output decode driving the datapath enables, mux selects and ALU select.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [1:0]       pc_source,
  output logic [SEL_W-1:0] alu_select
);

  state_t     state, state_next;
  ctrl_t      ctrl;
  logic [2:0] r_select, i_select;
  logic       r_supported, i_zero_ext;

  mips_alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct       (funct),
    .r_select    (r_select),
    .r_supported (r_supported),
    .i_select    (i_select),
    .i_zero_ext  (i_zero_ext)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; reset forces FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = S_FETCH;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.pc_write  = 1'b1;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:                      state_next = S_MEM_ADR;
          OP_RTYPE:                          state_next = S_R_EX;
          OP_BEQ:                            state_next = S_BRANCH;
          OP_J:                              state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_next = S_I_EX;
          default:                           state_next = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        state_next    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_R_EX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_select = r_select;
        state_next      = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = r_supported;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_select    = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_I_EX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.ext_zero   = i_zero_ext;
        ctrl.alu_select = i_select;
        state_next      = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ext_zero   = ctrl.ext_zero;
  assign pc_source  = ctrl.pc_source;
  assign alu_select = ctrl.alu_select;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: expected per-cycle control words
// are queued per instruction and compared against the DUT at each falling edge.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_select;
  } word_t;

  logic       clk, reset, zero;
  logic [5:0] opcode, funct;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, ext_zero;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_select;
  word_t      obs;

  int checks = 0;
  int errors = 0;

  word_t exp_q[$];
  string tag_q[$];

  mips_multicycle_control #(.SEL_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .pc_source  (pc_source),
    .alu_select (alu_select)
  );

  assign obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, alu_select};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t w_fetch();
    word_t c = '0;
    c.pc_en = 1'b1; c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01;
    return c;
  endfunction

  function automatic word_t w_decode();
    word_t c = '0;
    c.alu_src_b = 2'b11;
    return c;
  endfunction

  function automatic word_t w_mem_adr();
    word_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction

  function automatic word_t w_mem_rd();
    word_t c = '0;
    c.i_or_d = 1'b1; c.mem_read = 1'b1;
    return c;
  endfunction

  function automatic word_t w_mem_wb();
    word_t c = '0;
    c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
    return c;
  endfunction

  function automatic word_t w_mem_wr();
    word_t c = '0;
    c.i_or_d = 1'b1; c.mem_write = 1'b1;
    return c;
  endfunction

  function automatic word_t w_r_ex(input logic [2:0] sel);
    word_t c = '0;
    c.alu_src_a = 1'b1; c.alu_select = sel;
    return c;
  endfunction

  function automatic word_t w_r_wb(input logic ok);
    word_t c = '0;
    c.reg_dst = 1'b1; c.reg_write = ok;
    return c;
  endfunction

  function automatic word_t w_branch(input logic z);
    word_t c = '0;
    c.alu_src_a = 1'b1; c.alu_select = 3'b001; c.pc_source = 2'b01; c.pc_en = z;
    return c;
  endfunction

  function automatic word_t w_jump();
    word_t c = '0;
    c.pc_source = 2'b10; c.pc_en = 1'b1;
    return c;
  endfunction

  function automatic word_t w_i_ex(input logic [2:0] sel, input logic ze);
    word_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_zero = ze; c.alu_select = sel;
    return c;
  endfunction

  function automatic word_t w_i_wb();
    word_t c = '0;
    c.reg_write = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input word_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic push(input string tag, input word_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare one queued word per cycle, leaving the bench on the falling edge
  // after the last queued state.
  task automatic drain();
    word_t e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e);
      @(negedge clk);
    end
  endtask

  // Expected cycle-by-cycle control words for one instruction, from FETCH on.
  task automatic queue_instr(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input logic z);
    logic [2:0] rsel;
    logic       rok;
    push({name, "_fetch"}, w_fetch());
    push({name, "_decode"}, w_decode());
    rok = 1'b1;
    case (fn)
      6'h20: rsel = 3'b000;
      6'h22: rsel = 3'b001;
      6'h24: rsel = 3'b010;
      6'h25: rsel = 3'b011;
      6'h26: rsel = 3'b110;
      default: begin rsel = 3'b000; rok = 1'b0; end
    endcase
    case (op)
      6'h23: begin
        push({name, "_mem_adr"}, w_mem_adr());
        push({name, "_mem_rd"}, w_mem_rd());
        push({name, "_mem_wb"}, w_mem_wb());
      end
      6'h2B: begin
        push({name, "_mem_adr"}, w_mem_adr());
        push({name, "_mem_wr"}, w_mem_wr());
      end
      6'h00: begin
        push({name, "_r_ex"}, w_r_ex(rsel));
        push({name, "_r_wb"}, w_r_wb(rok));
      end
      6'h04: push({name, "_branch"}, w_branch(z));
      6'h02: push({name, "_jump"}, w_jump());
      6'h08: begin push({name, "_i_ex"}, w_i_ex(3'b000, 1'b0)); push({name, "_i_wb"}, w_i_wb()); end
      6'h0C: begin push({name, "_i_ex"}, w_i_ex(3'b010, 1'b1)); push({name, "_i_wb"}, w_i_wb()); end
      6'h0D: begin push({name, "_i_ex"}, w_i_ex(3'b011, 1'b1)); push({name, "_i_wb"}, w_i_wb()); end
      6'h0E: begin push({name, "_i_ex"}, w_i_ex(3'b110, 1'b1)); push({name, "_i_wb"}, w_i_wb()); end
      default: ;
    endcase
  endtask

  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
    queue_instr(name, op, fn, z);
    drain();
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    #1 reset = 1'b0;
    #2 check("reset_fetch", w_fetch());
    @(negedge clk);
    check("reset_hold", w_fetch());
    reset = 1'b1;

    run_instr("lw",       6'h23, 6'h00, 1'b0);
    run_instr("sw",       6'h2B, 6'h00, 1'b0);
    run_instr("r_add",    6'h00, 6'h20, 1'b0);
    run_instr("r_sub",    6'h00, 6'h22, 1'b1);
    run_instr("r_and",    6'h00, 6'h24, 1'b0);
    run_instr("r_or",     6'h00, 6'h25, 1'b0);
    run_instr("r_xor",    6'h00, 6'h26, 1'b0);
    run_instr("r_bad27",  6'h00, 6'h27, 1'b0);
    run_instr("beq_z1",   6'h04, 6'h00, 1'b1);
    run_instr("beq_z0",   6'h04, 6'h00, 1'b0);
    run_instr("j",        6'h02, 6'h00, 1'b1);
    run_instr("addi",     6'h08, 6'h00, 1'b0);
    run_instr("andi",     6'h0C, 6'h00, 1'b0);
    run_instr("ori",      6'h0D, 6'h00, 1'b0);
    run_instr("xori",     6'h0E, 6'h00, 1'b0);
    run_instr("op_3f",    6'h3F, 6'h20, 1'b1);
    run_instr("sw_again", 6'h2B, 6'h00, 1'b1);

    // Abort an lw in MEM_RD: reset must return to FETCH without the write-back.
    opcode = 6'h23;
    funct  = 6'h00;
    zero   = 1'b0;
    push("abort_fetch_pre", w_fetch());
    push("abort_decode",    w_decode());
    push("abort_mem_adr",   w_mem_adr());
    drain();
    check("abort_mem_rd", w_mem_rd());
    #2 reset = 1'b0;
    #1 check("abort_async_fetch", w_fetch());
    @(negedge clk);
    check("abort_held_fetch", w_fetch());
    reset = 1'b1;
    run_instr("post_abort_j",  6'h02, 6'h00, 1'b0);
    run_instr("post_abort_lw", 6'h23, 6'h00, 1'b0);
    check("final_fetch", w_fetch());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
